// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared types and helpers for the button debouncer.
//   deb_state_e : per-channel debounce FSM state
//   cnt_width() : width of the persistence counter for a given cycle count
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      WAIT_HI = 2'd1,
      ST_HI   = 2'd2,
      WAIT_LO = 2'd3
   } deb_state_e;

   // Counter must hold values up to max_count; never narrower than 1 bit.
   function automatic int cnt_width(input int max_count);
      int w;
      w = $clog2(max_count + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One debounced input: SYNC_STAGES-deep synchronizer, persistence FSM with
//   an up-counter, registered level output and one-cycle edge pulses.
//
//   clk     : clock for all logic
//   arst    : asynchronous active-high reset
//   ena     : sample enable; FSM and counter advance only while 1
//   din     : raw asynchronous level
//   dout    : debounced level
//   rising  : one-cycle pulse when dout goes 0->1
//   falling : one-cycle pulse when dout goes 1->0
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_LO   | settled low, watching for a high sample
//   WAIT_HI | high seen, counting consecutive enabled high samples
//   ST_HI   | settled high, watching for a low sample
//   WAIT_LO | low seen, counting consecutive enabled low samples
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic arst,
   input  logic ena,
   input  logic din,
   output logic dout,
   output logic rising,
   output logic falling
);

   localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   // A single agreeing sample is enough: skip the wait states entirely.
   localparam bit               DIRECT  = (DEBOUNCE_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_lvl;

   deb_state_e             state_q;
   deb_state_e             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   logic                   out_q;
   logic                   out_d;
   logic                   rise_q;
   logic                   rise_d;
   logic                   fall_q;
   logic                   fall_d;

   // Synchronizer runs every cycle; ena only gates the FSM.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= ST_LO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The counter holds the number of consecutive enabled
   // samples of the new level seen so far; the sample that finds it at
   // DEBOUNCE_CYCLES-1 is the last one needed, so the count tops out there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ena) begin
         case (state_q)
            ST_LO: begin
               if (sync_lvl) begin
                  if (DIRECT) begin
                     state_d = ST_HI;
                     cnt_d   = '0;
                  end else begin
                     state_d = WAIT_HI;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            WAIT_HI: begin
               if (!sync_lvl) begin
                  state_d = ST_LO;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_TC) begin
                  state_d = ST_HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HI: begin
               if (!sync_lvl) begin
                  if (DIRECT) begin
                     state_d = ST_LO;
                     cnt_d   = '0;
                  end else begin
                     state_d = WAIT_LO;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            WAIT_LO: begin
               if (sync_lvl) begin
                  state_d = ST_HI;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_TC) begin
                  state_d = ST_LO;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_LO;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output logic: the debounced level is a function of the next state, so
   // out, rising and falling all change on the same edge as the state.
   always_comb begin
      out_d  = (state_d == ST_HI) || (state_d == WAIT_LO);
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         out_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign dout    = out_q;
   assign rising  = rise_q;
   assign falling = fall_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   WIDTH independent debounced inputs sharing one clock, reset and enable.
//
//   clk     : clock for all logic
//   arst    : asynchronous active-high reset
//   ena     : sample-rate enable for the debounce FSMs and counters
//   in      : raw asynchronous button/switch levels
//   out     : debounced levels
//   rising  : one-cycle pulse per channel on each 0->1 change of out
//   falling : one-cycle pulse per channel on each 1->0 change of out
module button_debounce
   import debounce_pkg::*;
#(
   parameter int WIDTH           = 6,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1250000
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             ena,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rising,
   output logic [WIDTH-1:0] falling
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "button_debounce: SYNC_STAGES must be >= 2");
   end

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $fatal(1, "button_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .arst    (arst),
         .ena     (ena),
         .din     (in[i]),
         .dout    (out[i]),
         .rising  (rising[i]),
         .falling (falling[i])
      );
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 6, number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flip-flop depth; legal values >= 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1250000 (10 ms at 125 MHz), enabled cycles a new level must persist; legal values >= 1.
REQ-004 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-005 SHALL have port arst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port ena, input, 1 bit, sample-rate enable; FSM and counters advance only while ena is 1.
REQ-007 SHALL have port in, input, WIDTH bits, raw asynchronous button/switch levels.
REQ-008 SHALL have port out, output, WIDTH bits, debounced level per channel.
REQ-009 SHALL have port rising, output, WIDTH bits, one-cycle pulse on each 0->1 change of out.
REQ-010 SHALL have port falling, output, WIDTH bits, one-cycle pulse on each 1->0 change of out.

Function
REQ-011 Each channel SHALL pass in[i] through a SYNC_STAGES-deep flip-flop chain, clocked every cycle regardless of ena; the last stage is sync[i].
REQ-012 Each channel SHALL run an FSM with states ST_LO, WAIT_HI, ST_HI, WAIT_LO and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 In ST_LO with ena=1 and sync=1: go to WAIT_HI and load counter with 1; when DEBOUNCE_CYCLES=1, go directly to ST_HI instead.
REQ-014 In WAIT_HI with ena=1 and sync=1: increment counter; on the cycle counter equals DEBOUNCE_CYCLES-1, go to ST_HI.
REQ-015 In WAIT_HI with ena=1 and sync=0: return to ST_LO, clear counter, leave out unchanged, and emit no pulse.
REQ-016 ST_HI and WAIT_LO SHALL mirror REQ-013..015 with the levels inverted.
REQ-017 out[i] SHALL be registered and equal 1 exactly in states ST_HI and WAIT_LO.
REQ-018 rising[i] and falling[i] SHALL be registered and assert in the same cycle out[i] changes, for one clk cycle only.
REQ-019 With ena held at 1, out SHALL change exactly SYNC_STAGES + DEBOUNCE_CYCLES clk cycles after the first rising edge that samples a stable new level on in.
REQ-020 With ena=0, state, counter and out SHALL hold, and rising and falling SHALL be 0.
REQ-021 A pulse on in shorter than DEBOUNCE_CYCLES enabled cycles SHALL NOT change out.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL NOT wrap.
REQ-023 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 On arst=1, immediately and without waiting for a clock edge: synchronizer stages=0, state=ST_LO, counter=0, out=0, rising=0, falling=0.
REQ-025 Reset asserted mid-debounce SHALL abandon the count and SHALL NOT produce a pulse.
REQ-026 After arst deasserts, an in already held at 1 SHALL be treated as a new level and follow REQ-019.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state enum typedef and a counter-width function built on clog2.
REQ-028 One sub-module, debounce_channel, SHALL implement a single channel (synchronizer, FSM, counter, pulses); button_debounce SHALL instantiate WIDTH copies of it via generate.
REQ-029 Parameter legality (SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1) SHALL be checked at elaboration with a fatal error.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WIDTH=6, ena=1 unless stated)
REQ-030 Clean step: in[0] 0->1 and held -> out[0]=1 and rising[0]=1 exactly 6 cycles later, rising[0]=0 on the following cycle.
REQ-031 Glitch: in[1]=1 for 3 cycles, then 0 -> out[1] stays 0, rising[1] never asserts.
REQ-032 Bounce: in[2] toggles every cycle for 10 cycles, then held 1 -> out[2] rises exactly 6 cycles after the final 0->1 transition, with a single rising pulse.
REQ-033 Enable gating: ena pulsed 1 every 3rd cycle, in[3] steps to 1 -> out[3] rises only after 4 enabled cycles following synchronization; no pulses while ena=0.
REQ-034 Reset mid-count: in[4]=1 for 3 cycles, then arst pulsed with in still 1 -> all outputs 0 immediately, no pulse, out[4] rises 6 cycles after arst deasserts.
REQ-035 Simultaneous: in[5:0] 0x00->0x3F, held, then ->0x00 -> rising=0x3F in one cycle, then later falling=0x3F in one cycle, with equal 6-cycle latency.
